// File: rtl/conv_pixel_streamer.sv
// conv_pixel_streamer: raster-order pixel source from a sync-read RAM with hold/skid handling
// Define STREAMER_PAD_EN to append IMG_WIDTH+1 zero pixels after each frame.
module conv_pixel_streamer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rd_data,
  output logic [7:0]            data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = $clog2(N + 1);
`ifdef STREAMER_PAD_EN
  localparam int PW = $clog2(IMG_WIDTH + 2);
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, DONE, PAD} state_t;
  logic [PW-1:0] pad_cnt;
  logic          pad_emit;
`else
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
`endif
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          rd_pending, skid_valid, drain_ok;
  logic [7:0]    skid;
  assign drain_ok = !rd_pending && !skid_valid;
`ifdef STREAMER_PAD_EN
  assign pad_emit = state == PAD && !hold && pad_cnt < PW'(IMG_WIDTH + 1);
`endif
  always_comb begin
    mem_rd_en  = state == STREAM && !hold && cnt < CW'(N);
    mem_addr   = mem_rd_en ? ADDR_WIDTH'(cnt) : '0;
    busy       = state != IDLE && state != DONE;
    frame_done = state == DONE;
    state_nxt  = state;
    case (state)
      IDLE:   state_nxt = start ? STREAM : IDLE;
      STREAM: state_nxt = (mem_rd_en && cnt == CW'(N - 1)) ? DRAIN : STREAM;
`ifdef STREAMER_PAD_EN
      DRAIN:  state_nxt = drain_ok ? PAD : DRAIN;
      PAD:    state_nxt = pad_cnt == PW'(IMG_WIDTH + 1) ? DONE : PAD;
`else
      DRAIN:  state_nxt = drain_ok ? DONE : DRAIN;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_pending <= 1'b0;
      skid       <= '0;
      skid_valid <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= state == IDLE ? '0 : cnt + CW'(mem_rd_en);
      rd_pending <= mem_rd_en;
      // A read landing during hold parks in the skid; reads stop while held, so it never overflows.
      if (hold) begin
        valid_out <= 1'b0;
        if (rd_pending) begin
          skid       <= mem_rd_data;
          skid_valid <= 1'b1;
        end
      end else if (skid_valid) begin
        data_out   <= skid;
        valid_out  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (rd_pending) begin
        data_out  <= mem_rd_data;
        valid_out <= 1'b1;
`ifdef STREAMER_PAD_EN
      end else if (pad_emit) begin
        data_out  <= '0;
        valid_out <= 1'b1;
`endif
      end else begin
        valid_out <= 1'b0;
      end
    end
  end
`ifdef STREAMER_PAD_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pad_cnt <= '0;
    else pad_cnt <= state == PAD ? pad_cnt + PW'(pad_emit) : '0;
  end
`endif
endmodule

// File: tb/tb_conv_pixel_streamer.sv
// tb_conv_pixel_streamer: random-RAM frames checked against an in-order address/pixel model
module tb_conv_pixel_streamer;
  localparam int N = 64;
  logic       Clk = 1'b0, Rst = 1'b0, start = 1'b0, hold = 1'b0;
  logic       mem_rd_en, valid_out, busy, frame_done;
  logic [5:0] mem_addr;
  logic [7:0] mem_rd_data = 8'h00, data_out;
  logic [7:0] ram [N];
  int vectors = 0, miscompares = 0;

  always #5 Clk = ~Clk;

  conv_pixel_streamer #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .ADDR_WIDTH(6)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .frame_done(frame_done)
  );

  always @(posedge Clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ram;
    foreach (ram[i]) ram[i] = 8'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  // mode: 0 no hold, 1 five-cycle hold at pixel 20, 2 hold every other cycle, 3 random hold, 4 stray start pulses
  task automatic run_frame(input int mode, input bit launch, input bit keep_start);
    logic [7:0] got[$];
    int first_rd = 0, first_valid = 0, done = 0, busy_cyc = 0, low = 0, exp_addr = 0;
    bit prev_hold = 0;
    if (launch) begin
      @(posedge Clk); #1 start = 1'b1;
      @(posedge Clk); #1 start = keep_start;
    end
    for (int k = 1; k <= 600 && done == 0; k++) begin
      hold = mode == 1 ? (k >= 22 && k <= 26) : mode == 2 ? k[0] :
             mode == 3 ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (mode == 4) start = (k == 10 || k == 40);
      @(negedge Clk);
      if (prev_hold) chk("valid_after_hold", valid_out, 0);
      prev_hold = hold;
      if (mem_rd_en) begin
        chk($sformatf("mem_addr[%0d]", exp_addr), mem_addr, exp_addr);
        exp_addr++;
        if (first_rd == 0) first_rd = k;
      end
      if (valid_out) begin
        got.push_back(data_out);
        if (first_valid == 0) first_valid = k;
      end else if (first_valid != 0 && got.size() < N) low++;
      if (busy) busy_cyc++;
      if (frame_done) done = k;
      else begin
        @(posedge Clk); #1;
      end
    end
    hold = 1'b0;
    if (mode == 4) start = 1'b0;
    chk("frame_done_seen", done != 0, 1);
    chk("pixel_count", got.size(), N);
    for (int i = 0; i < got.size() && i < N; i++) chk($sformatf("pixel[%0d]", i), got[i], ram[i]);
    chk("reads_issued", exp_addr, N);
    if (mode == 0 || mode == 4) begin
      chk("first_rd_cycle", first_rd, 1);
      chk("first_valid_cycle", first_valid, 3);
      chk("done_cycle", done, N + 3);
      chk("busy_cycles", busy_cyc, N + 2);
    end
    if (mode == 1) begin
      chk("hold_gap_cycles", low, 5);
      chk("held_done_cycle", done, N + 8);
    end
    if (!keep_start) repeat (4) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("post_done_pulse", frame_done, 0);
      chk("post_done_busy", busy, 0);
    end
  endtask

  initial begin
    fill_ram;
    #12;
    chk_quiet("reset");
    @(negedge Clk) Rst = 1'b1;
    run_frame(0, 1, 0);
    fill_ram;
    run_frame(1, 1, 0);
    fill_ram;
    run_frame(2, 1, 0);
    fill_ram;
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    repeat (32) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("pre_reset_valid", valid_out, 1);
    chk("pre_reset_pixel30", data_out, ram[30]);
    #1 Rst = 1'b0;
    #1 chk_quiet("midframe_reset");
    repeat (3) begin
      @(negedge Clk);
      chk("reset_no_done", frame_done, 0);
    end
    Rst = 1'b1;
    @(negedge Clk);
    chk("after_reset_busy", busy, 0);
    chk("after_reset_done", frame_done, 0);
    fill_ram;
    run_frame(3, 1, 0);
    fill_ram;
    run_frame(4, 1, 0);
    fill_ram;
    run_frame(0, 1, 1);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", frame_done, 0);
    chk("b2b_idle_rd", mem_rd_en, 0);
    @(posedge Clk); #1 start = 1'b0;
    run_frame(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_pixel_streamer.md
# conv_pixel_streamer

Raster-order pixel source for the stride-2 3x3 convolution unit. On `start` it reads one frame of 8-bit pixels from a synchronous-read image RAM and streams them one per cycle on a `data_out`/`valid_out` pair that connects directly to the convolution unit's `data_in`/`valid_in`. It tolerates a one-cycle RAM read latency, supports stalling via `hold` without losing or duplicating pixels, and pulses `frame_done` after the last pixel.

## Interface
- `IMG_WIDTH`, 8: pixels per row, ≥ 3.
- `IMG_HEIGHT`, 8: rows per frame, ≥ 3.
- `ADDR_WIDTH`, 6: RAM address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH*IMG_HEIGHT.

Ports:
- `Clk`  in  1  the only clock; rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `hold`  in  1  stall request from downstream.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_addr`  out  ADDR_WIDTH  RAM read address, row-major: row*IMG_WIDTH + col.
- `mem_rd_data`  in  8  RAM data, valid on the cycle after `mem_rd_en`.
- `data_out`  out  8  pixel to the convolution unit.
- `valid_out`  out  1  `data_out` is valid this cycle.
- `busy`  out  1  high from start acceptance until `frame_done`.
- `frame_done`  out  1  single-cycle pulse after the last pixel.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE (plus PAD when `STREAMER_PAD_EN` is defined).
- IDLE → STREAM on `start`=1. `busy` rises on the same edge. The read counter clears to 0.
- STREAM:
  - Each cycle with `hold`=0 and read count < N (N = IMG_WIDTH*IMG_HEIGHT), drive `mem_rd_en`=1 and `mem_addr`=count, then increment count.
  - After read N-1 is issued, go to DRAIN.
- Data path: each `mem_rd_data` is registered into `data_out`, with `valid_out`=1.
- A one-entry skid register captures a read that returns while `hold`=1. That pixel is emitted first when `hold` drops.
- DRAIN: wait until the last returned pixel has been emitted (skid empty, no read in flight). Then go to DONE.
- DONE: `frame_done`=1 for exactly one cycle, `busy`=0. Next state is IDLE.
- `start` is ignored outside IDLE. `start` held high in IDLE re-launches a frame on the cycle after DONE.
- Output order is strictly addresses 0..N-1, with no gaps other than those caused by `hold`.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `data_out`=0, `valid_out`=0, `busy`=0, `frame_done`=0, state IDLE, skid empty.
- Latency:
  - `start` sampled at edge E0.
  - `mem_rd_en` is high in the cycle after E0.
  - The first `valid_out` is high 2 cycles after the first `mem_rd_en`.
- Throughput: 1 pixel per cycle when `hold`=0. An unstalled frame is N+3 cycles from the start edge to `frame_done`.
- Hold:
  - `hold`=1 in cycle t: no `mem_rd_en` in cycle t, and `valid_out`=0 from cycle t+1 on.
  - At most one in-flight read lands in the skid register.
  - `hold` falling in cycle t: the skid pixel appears in cycle t+1, and reads resume in cycle t.
- `hold` asserted with `valid_out` already registered: that pixel still counts as delivered. The convolution unit samples on its clock, so the pixel is not re-sent.
- `hold` in IDLE or DONE has no effect.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The frame is abandoned, with no `frame_done`.
- Counter width: ⌈log2(N+1)⌉ bits. No wrap-around beyond N.

## Configuration
- `STREAMER_PAD_EN` defined:
  - After DRAIN, FSM enters PAD and emits IMG_WIDTH+1 pixels of value 0x00 with `valid_out`=1. No RAM reads occur.
  - This flushes the convolution line buffers so the last window is produced.
  - `hold` stalls PAD the same way as STREAM.
  - `frame_done` follows the final pad pixel.
- Not defined: no PAD state; DRAIN goes directly to DONE.

## Test plan
- Reset, then `start` with RAM[i]=i (8x8, `hold`=0):
  - `mem_rd_en` appears 1 cycle after start.
  - `data_out` runs 0..63 on consecutive cycles, starting 3 cycles after start.
  - `frame_done` pulses at cycle 67 after start; `busy` is high for 66 cycles.
- `hold` high for 5 cycles while streaming around pixel 20:
  - Output sequence stays gapless-ordered 0..63, with no duplicates or drops.
  - `valid_out` is low for exactly 5 cycles.
- `hold` toggling every cycle through the whole frame: all 64 pixels are delivered in order, and `frame_done` fires once.
- Assert `Rst`=0 during pixel 30, then release:
  - All outputs are 0 immediately, with no `frame_done`.
  - A new `start` streams 0..63 correctly.
- `start` pulsed during STREAM: ignored, and exactly one frame is emitted. `start` held high continuously gives back-to-back frames with one IDLE cycle between them.
- With `STREAMER_PAD_EN`: after pixel 63, nine 0x00 pixels with `valid_out`=1 follow, then `frame_done`.
